// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin over WIDTH bits: one full-subtractor step per clock, LSB first, borrow kept in a flop.
// Latency: done pulses WIDTH+1 cycles after the accepted start edge; busy spans WIDTH+2 cycles.
// Backpressure: none; start is sampled only in IDLE and is ignored while an operation runs (no queuing).
// Optional flags: define SERIAL_SUB_FLAGS_EN to add the registered zero/ovf outputs.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    // Counter is at least one bit wide so WIDTH=1 still has a legal vector.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             cell_a;
    logic             cell_b;
    logic             cell_d;
    logic             cell_bout;
    // Cell difference bit concatenated above sd; the upper WIDTH bits are sd after one right shift.
    logic [WIDTH:0]   sd_cat;

`ifdef SERIAL_SUB_FLAGS_EN
    // Operand MSBs from the accepted start, needed for the overflow term after the operands shift out.
    logic             a_msb;
    logic             b_msb;
`endif

    // One-bit full subtractor evaluated on the current LSBs and the held borrow.
    always_comb begin
        cell_a    = sa[0];
        cell_b    = sb[0];
        cell_d    = cell_a ^ cell_b ^ br;
        cell_bout = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & br);
        sd_cat    = {cell_d, sd};
    end

    // Sequencer: capture in IDLE, one bit per cycle in RUN, publish the result from DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // busy follows an accepted start so back-to-back operations keep it high.
                    busy <= start;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= RUN;
`ifdef SERIAL_SUB_FLAGS_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    sd <= sd_cat[WIDTH:1];
                    br <= cell_bout;
                    // Counter saturates on the last bit so WIDTH=1 keeps it at zero.
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    d     <= sd;
                    bout  <= br;
                    done  <= 1'b1;
                    state <= IDLE;
`ifdef SERIAL_SUB_FLAGS_EN
                    zero  <= (sd == '0);
                    ovf   <= (a_msb ^ b_msb) & (sd[WIDTH-1] ^ a_msb);
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

    localparam int W8 = 8;

    logic clk;
    logic rstn;

    logic          start8;
    logic [W8-1:0] a8;
    logic [W8-1:0] b8;
    logic          bin8;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] d8;
    logic          bout8;

    logic start1;
    logic a1;
    logic b1;
    logic bin1;
    logic busy1;
    logic done1;
    logic d1;
    logic bout1;

`ifdef SERIAL_SUB_FLAGS_EN
    logic zero8;
    logic ovf8;
    logic zero1;
    logic ovf1;
`endif

    serial_sub_ctrl #(.WIDTH(W8)) u8 (
        .clk   (clk),
        .rstn  (rstn),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .d     (d8),
        .bout  (bout8)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero  (zero8),
        .ovf   (ovf8)
`endif
    );

    serial_sub_ctrl #(.WIDTH(1)) u1 (
        .clk   (clk),
        .rstn  (rstn),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .d     (d1),
        .bout  (bout1)
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero  (zero1),
        .ovf   (ovf1)
`endif
    );

    typedef struct packed {
        logic [7:0] d;
        logic       bout;
        logic       zero;
        logic       ovf;
    } exp8_t;

    typedef struct packed {
        logic d;
        logic bout;
    } exp1_t;

    exp8_t q8[$];
    exp1_t q1[$];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction, unsigned borrow, signed-overflow rule on MSBs.
    function automatic exp8_t model8(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
        exp8_t r;
        int    diff;
        diff   = int'(ma) - int'(mb) - int'(mbin);
        r.d    = 8'(diff);
        r.bout = (diff < 0);
        r.zero = (r.d == 8'h00);
        r.ovf  = (ma[7] ^ mb[7]) & (r.d[7] ^ ma[7]);
        return r;
    endfunction

    function automatic exp1_t model1(input logic ma, input logic mb, input logic mbin);
        exp1_t r;
        int    diff;
        diff   = int'(ma) - int'(mb) - int'(mbin);
        r.d    = 1'(diff);
        r.bout = (diff < 0);
        return r;
    endfunction

    // Scoreboard monitor for the 8-bit instance; also checks d holds between results.
    logic [7:0] last_d8 = '0;
    always @(negedge clk) begin
        exp8_t e;
        if (!rstn) begin
            last_d8 = '0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 32'(done8), 32'd0);
            end else begin
                e = q8.pop_front();
                chk("w8_d", 32'(d8), 32'(e.d));
                chk("w8_bout", 32'(bout8), 32'(e.bout));
`ifdef SERIAL_SUB_FLAGS_EN
                chk("w8_zero", 32'(zero8), 32'(e.zero));
                chk("w8_ovf", 32'(ovf8), 32'(e.ovf));
`endif
            end
            last_d8 = d8;
        end else begin
            chk("w8_d_hold", 32'(d8), 32'(last_d8));
        end
    end

    // Scoreboard monitor for the 1-bit instance.
    always @(negedge clk) begin
        exp1_t e;
        if (rstn && done1) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected_done", 32'(done1), 32'd0);
            end else begin
                e = q1.pop_front();
                chk("w1_d", 32'(d1), 32'(e.d));
                chk("w1_bout", 32'(bout1), 32'(e.bout));
            end
        end
    end

    // One 8-bit operation from idle: latency, busy window, optional ignored start at edge ign_at+1.
    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input int ign_at);
        int n;
        int busy_cnt;
        bit seen;
        a8     = ia;
        b8     = ib;
        bin8   = ibin;
        start8 = 1'b1;
        q8.push_back(model8(ia, ib, ibin));
        @(posedge clk);
        #1;
        start8   = 1'b0;
        n        = 0;
        busy_cnt = busy8 ? 1 : 0;
        seen     = 1'b0;
        while (!seen && n < 40) begin
            if (n == ign_at) begin
                start8 = 1'b1;
                a8     = 8'($urandom);
                b8     = 8'($urandom);
                bin8   = 1'($urandom);
            end
            @(posedge clk);
            #1;
            start8 = 1'b0;
            n++;
            if (busy8) busy_cnt++;
            if (done8) seen = 1'b1;
        end
        if (!seen) begin
            chk("w8_done_timeout", 32'd0, 32'd1);
        end else begin
            chk("w8_latency", 32'(n), 32'(W8 + 1));
            @(posedge clk);
            #1;
            chk("w8_busy_cycles", 32'(busy_cnt), 32'(W8 + 2));
            chk("w8_busy_falls", 32'(busy8), 32'd0);
            chk("w8_done_pulse", 32'(done8), 32'd0);
        end
    endtask

    task automatic issue1(input logic ia, input logic ib, input logic ibin);
        int n;
        bit seen;
        a1     = ia;
        b1     = ib;
        bin1   = ibin;
        start1 = 1'b1;
        q1.push_back(model1(ia, ib, ibin));
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n      = 0;
        seen   = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done1) seen = 1'b1;
        end
        if (!seen) begin
            chk("w1_done_timeout", 32'd0, 32'd1);
        end else begin
            chk("w1_latency", 32'(n), 32'd2);
            @(posedge clk);
            #1;
            chk("w1_busy_falls", 32'(busy1), 32'd0);
        end
    endtask

    initial begin
        rstn   = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        bin8   = 1'b0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        bin1   = 1'b0;
        #2;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_d", 32'(d8), 32'd0);
        chk("rst_bout", 32'(bout8), 32'd0);
        chk("rst_w1_busy", 32'(busy1), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
        chk("rst_zero", 32'(zero8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
`endif
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases, including an ignored mid-run start.
        issue8(8'h35, 8'h12, 1'b0, -1);
        issue8(8'h00, 8'h01, 1'b0, -1);
        issue8(8'h80, 8'h01, 1'b0, -1);
        issue8(8'h10, 8'h0F, 1'b1, 3);

        // start held high: operands recaptured every W8+2 edges, junk in between is ignored.
        for (int k = 0; k < 5; k++) begin
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            bin8   = 1'($urandom);
            start8 = 1'b1;
            q8.push_back(model8(a8, b8, bin8));
            for (int c = 0; c < W8 + 2; c++) begin
                @(posedge clk);
                #1;
                chk("held_done", 32'(done8), 32'(c == W8 + 1));
                chk("held_busy", 32'(busy8), 32'd1);
                if (c < W8 + 1) begin
                    a8   = 8'($urandom);
                    b8   = 8'($urandom);
                    bin8 = 1'($urandom);
                end
            end
        end
        start8 = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // Reset during RUN bit 4 aborts the operation; outputs clear at once.
        issue8(8'hC3, 8'h21, 1'b0, -1);
        a8     = 8'h5A;
        b8     = 8'h13;
        bin8   = 1'b1;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_d", 32'(d8), 32'd0);
        chk("abort_bout", 32'(bout8), 32'd0);
        q8.delete();
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        issue8(8'hFF, 8'hFF, 1'b0, -1);

        // Random operations, some with an ignored start during RUN.
        for (int i = 0; i < 30; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom),
                   ($urandom_range(1) == 1) ? int'($urandom_range(W8 - 1)) : -1);
        end

        // WIDTH=1: full-subtractor truth table.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] abc;
            abc = 3'(v);
            issue1(abc[2], abc[1], abc[0]);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("w8_queue_empty", 32'(q8.size()), 32'd0);
        chk("w1_queue_empty", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller. It computes `a - b - bin` over a WIDTH-bit word by sequencing a single `sub_1_bit` full-subtractor cell LSB-first, one bit per clock. The borrow is held in a flop between bit steps. The block sits between a register-file or host interface and the one-bit subtractor datapath, with a start/busy/done handshake on the host side.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 1..32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on the accepted start.
- `b`  in  WIDTH  subtrahend; captured on the accepted start.
- `bin`  in  1  initial borrow; captured on the accepted start.
- `busy`  out  1  high while an operation is in progress (RUN or DONE).
- `done`  out  1  one-cycle pulse; the result is valid from this cycle onward.
- `d`  out  WIDTH  registered difference.
- `bout`  out  1  registered final borrow.
- `zero`  out  1  d == 0 (only with SERIAL_SUB_FLAGS_EN).
- `ovf`  out  1  two's-complement overflow (only with SERIAL_SUB_FLAGS_EN).

## Operation
- Internal state:
  - operand shift registers `sa` and `sb`
  - result shift register `sd`
  - borrow flop `br`
  - bit counter `cnt`, width clog2(WIDTH), minimum 1
  - FSM with states IDLE, RUN, DONE
- IDLE:
  - If `start` = 1: `sa` <= `a`, `sb` <= `b`, `br` <= `bin`, `cnt` <= 0, next state RUN.
  - Otherwise stay in IDLE.
- RUN, one cell evaluation per cycle:
  - Cell inputs: A = `sa[0]`, B = `sb[0]`, Bin = `br`.
  - Cell equations: D = A^B^Bin; Bout = (~A&B) | (~(A^B)&Bin).
  - `sa` and `sb` shift right.
  - Cell D shifts into `sd[WIDTH-1]`, with `sd` shifting right.
  - `br` <= cell Bout.
  - `cnt` increments.
  - When `cnt` == WIDTH-1, that cycle's update is the final bit; next state DONE.
- DONE, for one cycle:
  - `d` <= `sd`, `bout` <= `br`, `done` = 1.
  - Next state IDLE.
- `d` and `bout` change only on entry to DONE. They hold the last result through IDLE and the next RUN.
- `start` is ignored in RUN and DONE; there is no queuing.
- `start` held high continuously gives back-to-back operations every WIDTH+2 cycles.
- Arithmetic is modulo 2^WIDTH. `bout` = 1 iff a < b + bin, treating all operands as unsigned.

## Timing
- Reset values: `busy` = 0, `done` = 0, `d` = 0, `bout` = 0, `zero` = 0, `ovf` = 0. The FSM resets to IDLE, and `sa`/`sb`/`sd`/`br`/`cnt` reset to 0.
- Reset asserted mid-operation aborts immediately. The outputs go to their reset values asynchronously, and the aborted result is never presented.
- Let edge 0 be the edge that samples `start`:
  - `busy` rises after edge 0.
  - RUN occupies edges 1..WIDTH.
  - `done` and the new `d`/`bout` are visible after edge WIDTH+1.
  - `busy` falls after edge WIDTH+2.
- Latency from the start edge to `done` is WIDTH+1 cycles.
- `done` is high for exactly one cycle.
- `busy` and `done` are registered outputs; no output has a combinational path from an input.
- WIDTH = 1: RUN lasts a single cycle, and `cnt` stays at 0.

## Configuration
- Macro: `SERIAL_SUB_FLAGS_EN`.
- Defined:
  - `zero` and `ovf` ports exist and are registered alongside `d` on DONE entry.
  - `zero` = (`sd` == 0).
  - `ovf` = (a[MSB]^b[MSB]) & (d[MSB]^a[MSB]), using the operands captured at start; the MSBs are held in two extra flops.
  - `bin` is not included in the `ovf` term.
- Undefined: the `zero` and `ovf` ports and their logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, a=0x35, b=0x12, bin=0 -> d=0x23, bout=0; `done` is high 9 cycles after the start edge; `busy` is high for 10 cycles.
- WIDTH=8, a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1, ovf=0. Then a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1.
- WIDTH=8, a=0x10, b=0x0F, bin=1 -> d=0x00, bout=0, zero=1. A `start` pulse during RUN is ignored, and `d` stays at the prior result until DONE.
- WIDTH=8, `start` held high -> `done` pulses every 10 cycles, and the operands are recaptured each time in IDLE.
- `rstn` low at RUN bit 4 -> `busy`, `done`, `d` and `bout` are 0 immediately; after release, a fresh a=0xFF, b=0xFF, bin=0 -> d=0x00, bout=0.
- WIDTH=1, all 8 {a,b,bin} combinations -> (d, bout) = 00, 11, 11, 01, 10, 00, 00, 11, matching the full-subtractor truth table.
